// File: rtl/mips_pipe_pkg.sv
// Shared fetch-pipe types: PC width, reset PC, BHT counter encodings and the BTB entry layout.
package mips_pipe_pkg;
  localparam int PC_W = 32;
  localparam int TAG_W = PC_W - 2;
  localparam logic [PC_W-1:0] RESET_PC_DEF = 32'h0000_0000;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } bht_cnt_e;

  // Tag field is sized for the smallest index width; narrower tags are zero-extended.
  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [PC_W-1:0]  target;
  } btb_entry_t;

  function automatic bht_cnt_e bht_next(input bht_cnt_e cnt, input logic taken);
    bht_cnt_e nxt;
    nxt = cnt;
    case (cnt)
      SNT: nxt = taken ? WNT : SNT;
      WNT: nxt = taken ? WT  : SNT;
      WT:  nxt = taken ? ST  : WNT;
      ST:  nxt = taken ? ST  : WT;
      default: nxt = WNT;
    endcase
    return nxt;
  endfunction

  function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] addr);
    return {addr[PC_W-1:2], 2'b00};
  endfunction
endpackage

// File: rtl/bht_btb_table.sv
// Direct-mapped BHT (2-bit saturating counters) plus BTB: combinational read, synchronous write.
module bht_btb_table
  import mips_pipe_pkg::*;
#(
  parameter int IDX_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [PC_W-1:0] rd_pc,
  input  logic            wr_en,
  input  logic [PC_W-1:0] wr_pc,
  input  logic            wr_taken,
  input  logic [PC_W-1:0] wr_target,
  output logic            rd_pred,
  output logic [PC_W-1:0] rd_target
);
  localparam int DEPTH = 1 << IDX_W;

  bht_cnt_e   bht [DEPTH];
  btb_entry_t btb [DEPTH];

  logic [IDX_W-1:0] rd_idx;
  logic [IDX_W-1:0] wr_idx;
  logic [TAG_W-1:0] rd_tag;
  logic [TAG_W-1:0] wr_tag;
  logic             rd_hit;
  logic             unused_low;

  assign rd_idx = rd_pc[IDX_W+1:2];
  assign wr_idx = wr_pc[IDX_W+1:2];
  assign rd_tag = TAG_W'(rd_pc >> (IDX_W + 2));
  assign wr_tag = TAG_W'(wr_pc >> (IDX_W + 2));
  assign unused_low = ^{rd_pc[1:0], wr_pc[1:0]};

  // Reads see the pre-write contents; a same-index update shows up next cycle.
  assign rd_hit    = btb[rd_idx].valid && (btb[rd_idx].tag == rd_tag);
  assign rd_pred   = rd_hit && bht[rd_idx][1];
  assign rd_target = rd_hit ? btb[rd_idx].target : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        bht[i] <= WNT;
        btb[i] <= '0;
      end
    end else if (wr_en) begin
      bht[wr_idx] <= bht_next(bht[wr_idx], wr_taken);
      // Not-taken outcomes only weaken the counter; the BTB entry is kept.
      if (wr_taken) begin
        btb[wr_idx] <= '{valid: 1'b1, tag: wr_tag, target: wr_target};
      end
    end
  end
endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch PC register, mispredict detection and next-PC mux.
// FETCH_DYN_PRED_EN builds the BHT/BTB predictor; otherwise fetch is static not-taken.
module fetch_pc_unit
  import mips_pipe_pkg::*;
#(
  parameter int              IDX_W    = 6,
  parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall_fetch_hz_i,
  input  logic            jump_iss_ex_hz_i,
  input  logic [PC_W-1:0] jump_target_iss_i,
  input  logic            upd_valid_ex_i,
  input  logic [PC_W-1:0] upd_pc_ex_i,
  input  logic            upd_taken_ex_i,
  input  logic [PC_W-1:0] upd_target_ex_i,
  input  logic            upd_pred_ex_i,
  input  logic [PC_W-1:0] upd_pred_target_ex_i,
  output logic [PC_W-1:0] pc_o,
  output logic [PC_W-1:0] pc_plus4_o,
  output logic            brn_pred_o,
  output logic [PC_W-1:0] pred_target_o,
  output logic            redirect_o
);
  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] pc_next;
  logic [PC_W-1:0] upd_tgt_al;
  logic [PC_W-1:0] upd_fall;
  logic            mispredict;

  assign upd_tgt_al = align_pc(upd_target_ex_i);
  assign upd_fall   = align_pc(upd_pc_ex_i) + 32'd4;

`ifdef FETCH_DYN_PRED_EN
  logic unused_low;
  assign unused_low = ^{jump_target_iss_i[1:0], upd_target_ex_i[1:0],
                        upd_pred_target_ex_i[1:0], upd_pc_ex_i[1:0]};

  assign mispredict = upd_valid_ex_i &
                      ((upd_taken_ex_i != upd_pred_ex_i) |
                       (upd_taken_ex_i & upd_pred_ex_i &
                        (upd_tgt_al != align_pc(upd_pred_target_ex_i))));

  bht_btb_table #(.IDX_W(IDX_W)) u_table (
    .clk       (clk),
    .rst       (rst),
    .rd_pc     (pc_q),
    .wr_en     (upd_valid_ex_i),
    .wr_pc     (upd_pc_ex_i),
    .wr_taken  (upd_taken_ex_i),
    .wr_target (upd_tgt_al),
    .rd_pred   (brn_pred_o),
    .rd_target (pred_target_o)
  );
`else
  logic unused_static;
  assign unused_static = ^{upd_pred_ex_i, upd_pred_target_ex_i, jump_target_iss_i[1:0],
                           upd_target_ex_i[1:0], upd_pc_ex_i[1:0]};

  // Every branch is fetched as not-taken, so any taken resolution is a redirect.
  assign mispredict    = upd_valid_ex_i & upd_taken_ex_i;
  assign brn_pred_o    = 1'b0;
  assign pred_target_o = '0;
`endif

  assign pc_o       = pc_q;
  assign pc_plus4_o = pc_q + 32'd4;
  assign redirect_o = mispredict;

  // Mispredict outranks the issue-stage jump, which sits on the wrong path.
  always_comb begin
    pc_next = pc_plus4_o;
    if (mispredict) begin
      pc_next = upd_taken_ex_i ? upd_tgt_al : upd_fall;
    end else if (jump_iss_ex_hz_i) begin
      pc_next = align_pc(jump_target_iss_i);
    end else if (stall_fetch_hz_i) begin
      pc_next = pc_q;
    end else if (brn_pred_o) begin
      pc_next = pred_target_o;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= align_pc(RESET_PC);
    end else begin
      pc_q <= pc_next;
    end
  end
endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit; expectations follow FETCH_DYN_PRED_EN when it is defined.
module tb_fetch_pc_unit;
`ifdef FETCH_DYN_PRED_EN
  localparam bit DYN = 1'b1;
`else
  localparam bit DYN = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        stall;
  logic        jump;
  logic [31:0] jtgt;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_tgt;
  logic        upd_pred;
  logic [31:0] upd_ptgt;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        brn_pred;
  logic [31:0] pred_target;
  logic        redirect;

  int errors = 0;
  int checks = 0;

  fetch_pc_unit #(.IDX_W(6), .RESET_PC(32'h0)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .stall_fetch_hz_i     (stall),
    .jump_iss_ex_hz_i     (jump),
    .jump_target_iss_i    (jtgt),
    .upd_valid_ex_i       (upd_valid),
    .upd_pc_ex_i          (upd_pc),
    .upd_taken_ex_i       (upd_taken),
    .upd_target_ex_i      (upd_tgt),
    .upd_pred_ex_i        (upd_pred),
    .upd_pred_target_ex_i (upd_ptgt),
    .pc_o                 (pc),
    .pc_plus4_o           (pc_plus4),
    .brn_pred_o           (brn_pred),
    .pred_target_o        (pred_target),
    .redirect_o           (redirect)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    stall = 0; jump = 0; jtgt = 0;
    upd_valid = 0; upd_pc = 0; upd_taken = 0; upd_tgt = 0; upd_pred = 0; upd_ptgt = 0;
  endtask

  task automatic drive_upd(input logic [31:0] bpc, input logic taken, input logic [31:0] tgt,
                           input logic pred, input logic [31:0] ptgt);
    upd_valid = 1; upd_pc = bpc; upd_taken = taken; upd_tgt = tgt; upd_pred = pred; upd_ptgt = ptgt;
    #1;
  endtask

  task automatic goto_pc(input logic [31:0] addr);
    jump = 1; jtgt = addr;
    tick();
    jump = 0; jtgt = 0;
    #1;
  endtask

  // scenarios
  task automatic test_reset();
    clear_inputs();
    rst = 1;
    tick(); tick();
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h expected %h", pc, 32'h0); end
    checks++; if (brn_pred !== 1'b0) begin errors++; $display("FAIL reset_pred: got %b expected 0", brn_pred); end
    checks++; if (pred_target !== 32'h0) begin errors++; $display("FAIL reset_ptgt: got %h expected 0", pred_target); end
    checks++; if (redirect !== 1'b0) begin errors++; $display("FAIL reset_redirect: got %b expected 0", redirect); end
    rst = 0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      checks++; if (pc !== 32'(i * 4)) begin errors++; $display("FAIL seq_pc%0d: got %h expected %h", i, pc, 32'(i * 4)); end
      checks++; if (brn_pred !== 1'b0) begin errors++; $display("FAIL seq_pred%0d: got %b expected 0", i, brn_pred); end
    end
    checks++; if (pc_plus4 !== 32'h10) begin errors++; $display("FAIL seq_plus4: got %h expected %h", pc_plus4, 32'h10); end
  endtask

  task automatic test_stall_jump();
    tick();
    checks++; if (pc !== 32'h10) begin errors++; $display("FAIL pre_stall_pc: got %h expected %h", pc, 32'h10); end
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (pc !== 32'h10) begin errors++; $display("FAIL stall_hold%0d: got %h expected %h", i, pc, 32'h10); end
    end
    jump = 1; jtgt = 32'h200;
    tick();
    checks++; if (pc !== 32'h200) begin errors++; $display("FAIL jump_over_stall: got %h expected %h", pc, 32'h200); end
    clear_inputs();
  endtask

  task automatic test_training();
    drive_upd(32'h40, 1, 32'h100, 0, 32'h0);
    checks++; if (redirect !== 1'b1) begin errors++; $display("FAIL train1_redirect: got %b expected 1", redirect); end
    tick();
    checks++; if (pc !== 32'h100) begin errors++; $display("FAIL train1_pc: got %h expected %h", pc, 32'h100); end
    clear_inputs();
    goto_pc(32'h40);
    checks++; if (brn_pred !== DYN) begin errors++; $display("FAIL train_pred: got %b expected %b", brn_pred, DYN); end
    checks++; if (pred_target !== (DYN ? 32'h100 : 32'h0)) begin errors++; $display("FAIL train_ptgt: got %h expected %h", pred_target, DYN ? 32'h100 : 32'h0); end
    tick();
    checks++; if (pc !== (DYN ? 32'h100 : 32'h44)) begin errors++; $display("FAIL train_follow: got %h expected %h", pc, DYN ? 32'h100 : 32'h44); end
    drive_upd(32'h40, 1, 32'h100, DYN, DYN ? 32'h100 : 32'h0);
    checks++; if (redirect !== !DYN) begin errors++; $display("FAIL train2_redirect: got %b expected %b", redirect, !DYN); end
    tick();
    checks++; if (pc !== (DYN ? 32'h104 : 32'h100)) begin errors++; $display("FAIL train2_pc: got %h expected %h", pc, DYN ? 32'h104 : 32'h100); end
    clear_inputs();
  endtask

  task automatic test_pred_not_taken();
    drive_upd(32'h40, 0, 32'h0, 1, 32'h100);
    jump = 1; jtgt = 32'h300;
    #1;
    checks++; if (redirect !== DYN) begin errors++; $display("FAIL nt_redirect: got %b expected %b", redirect, DYN); end
    tick();
    checks++; if (pc !== (DYN ? 32'h44 : 32'h300)) begin errors++; $display("FAIL nt_pc: got %h expected %h", pc, DYN ? 32'h44 : 32'h300); end
    clear_inputs();
    goto_pc(32'h40);
    checks++; if (brn_pred !== DYN) begin errors++; $display("FAIL nt_once_pred: got %b expected %b", brn_pred, DYN); end
    drive_upd(32'h40, 0, 32'h0, 1, 32'h100);
    tick();
    clear_inputs();
    goto_pc(32'h40);
    checks++; if (brn_pred !== 1'b0) begin errors++; $display("FAIL nt_twice_pred: got %b expected 0", brn_pred); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      drive_upd(32'h40, 1, 32'h100, 1, 32'h100);
      checks++; if (redirect !== !DYN) begin errors++; $display("FAIL b2b_redirect%0d: got %b expected %b", i, redirect, !DYN); end
      tick();
    end
    drive_upd(32'h40, 0, 32'h0, 1, 32'h100);
    tick();
    clear_inputs();
    goto_pc(32'h40);
    checks++; if (brn_pred !== DYN) begin errors++; $display("FAIL saturate_pred: got %b expected %b", brn_pred, DYN); end
  endtask

  task automatic test_target_mismatch();
    drive_upd(32'h40, 1, 32'h180, 1, 32'h100);
    checks++; if (redirect !== 1'b1) begin errors++; $display("FAIL tmis_redirect: got %b expected 1", redirect); end
    tick();
    checks++; if (pc !== 32'h180) begin errors++; $display("FAIL tmis_pc: got %h expected %h", pc, 32'h180); end
    clear_inputs();
    goto_pc(32'h40);
    checks++; if (pred_target !== (DYN ? 32'h180 : 32'h0)) begin errors++; $display("FAIL tmis_ptgt: got %h expected %h", pred_target, DYN ? 32'h180 : 32'h0); end
    tick();
    checks++; if (pc !== (DYN ? 32'h180 : 32'h44)) begin errors++; $display("FAIL tmis_follow: got %h expected %h", pc, DYN ? 32'h180 : 32'h44); end
  endtask

  task automatic test_alias_wrap();
    goto_pc(32'h1040);
    checks++; if (brn_pred !== 1'b0) begin errors++; $display("FAIL alias_pred: got %b expected 0", brn_pred); end
    tick();
    checks++; if (pc !== 32'h1044) begin errors++; $display("FAIL alias_pc: got %h expected %h", pc, 32'h1044); end
    goto_pc(32'hFFFF_FFFF);
    checks++; if (pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL align_jump: got %h expected %h", pc, 32'hFFFF_FFFC); end
    checks++; if (pc_plus4 !== 32'h0) begin errors++; $display("FAIL wrap_plus4: got %h expected 0", pc_plus4); end
    tick();
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL wrap_pc: got %h expected 0", pc); end
  endtask

  task automatic test_same_cycle();
    goto_pc(32'h80);
    drive_upd(32'h80, 1, 32'h282, 0, 32'h0);
    checks++; if (brn_pred !== 1'b0) begin errors++; $display("FAIL same_old_pred: got %b expected 0", brn_pred); end
    tick();
    checks++; if (pc !== 32'h280) begin errors++; $display("FAIL same_redirect_pc: got %h expected %h", pc, 32'h280); end
    clear_inputs();
    goto_pc(32'h80);
    checks++; if (brn_pred !== DYN) begin errors++; $display("FAIL same_new_pred: got %b expected %b", brn_pred, DYN); end
    checks++; if (pred_target !== (DYN ? 32'h280 : 32'h0)) begin errors++; $display("FAIL same_new_ptgt: got %h expected %h", pred_target, DYN ? 32'h280 : 32'h0); end
  endtask

  task automatic test_reset_mid();
    rst = 1;
    drive_upd(32'hC0, 1, 32'h100, 0, 32'h0);
    tick();
    rst = 0;
    clear_inputs();
    #1;
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL mid_reset_pc: got %h expected 0", pc); end
    goto_pc(32'hC0);
    checks++; if (brn_pred !== 1'b0) begin errors++; $display("FAIL mid_reset_upd: got %b expected 0", brn_pred); end
    goto_pc(32'h40);
    checks++; if (brn_pred !== 1'b0) begin errors++; $display("FAIL mid_reset_clear: got %b expected 0", brn_pred); end
  endtask

  initial begin
    rst = 1;
    clear_inputs();
    test_reset();
    test_stall_jump();
    test_training();
    test_pred_not_taken();
    test_back_to_back();
    test_target_mismatch();
    test_alias_wrap();
    test_same_cycle();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
